// File: rtl/cmd_response_ctrl_if.sv
// Handshake bundle between the CMD top-level FSM / CMD line and the
// response controller.
//   master : CMD FSM side - drives start_rx, long_resp, cmd_in, observes status
//   slave  : cmd_response_ctrl - drives deserializer controls and status
interface cmd_response_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start_rx;
  logic             long_resp;
  logic             cmd_in;
  logic             des_enable;
  logic             des_reset;
  logic             rx_busy;
  logic             resp_done;
  logic             timeout_err;
  logic             dir_bit_err;
  logic             end_bit_err;
  logic [CNT_W-1:0] bit_index;

  modport master (
    output start_rx, long_resp, cmd_in,
    input  des_enable, des_reset, rx_busy, resp_done,
           timeout_err, dir_bit_err, end_bit_err, bit_index
  );

  modport slave (
    input  start_rx, long_resp, cmd_in,
    output des_enable, des_reset, rx_busy, resp_done,
           timeout_err, dir_bit_err, end_bit_err, bit_index
  );
endinterface

// File: rtl/cmd_response_ctrl.sv
// CMD-line response sequencer. After start_rx it waits up to TIMEOUT cycles
// for the card's start bit, then holds the deserializer enabled for exactly
// one 48- or 136-bit frame, checking the transmission and end bits.
// Ports:
//   sd_clock : clock, all state on posedge
//   reset    : asynchronous active-high reset
//   bus      : cmd_response_ctrl_if.slave
//              in  start_rx, long_resp, cmd_in
//              out des_enable, des_reset, rx_busy, resp_done,
//                  timeout_err, dir_bit_err, end_bit_err, bit_index
module cmd_response_ctrl #(
  parameter int TIMEOUT   = 64,
  parameter int SHORT_LEN = 48,
  parameter int LONG_LEN  = 136,
  parameter int CNT_W     = 8
) (
  input logic               sd_clock,
  input logic               reset,
  cmd_response_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_LEN - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, DONE} state_t;

  state_t           state, state_n;
  logic             is_long;
  logic [CNT_W-1:0] tcnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             des_reset_q;
  logic             timeout_q, dir_q, end_q;
  logic             des_enable_c, rx_busy_c, resp_done_c;
  logic [CNT_W-1:0] last_idx;

  assign last_idx = is_long ? LONG_LAST : SHORT_LAST;

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    des_enable_c = 1'b0;
    rx_busy_c    = 1'b0;
    resp_done_c  = 1'b0;
    unique case (state)
      IDLE: if (bus.start_rx) state_n = WAIT_START;
      WAIT_START: begin
        rx_busy_c    = 1'b1;
        // Combinational so the start bit itself is captured on the edge
        // that detects it.
        des_enable_c = ~bus.cmd_in;
        // A start bit on the last allowed cycle wins over the timeout.
        if (!bus.cmd_in)             state_n = RECEIVE;
        else if (tcnt == TO_LAST)    state_n = DONE;
      end
      RECEIVE: begin
        rx_busy_c    = 1'b1;
        des_enable_c = 1'b1;
        if (bit_cnt == last_idx) state_n = DONE;
      end
      DONE: begin
        resp_done_c = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: counters and sticky flags. Flags and bit count hold after DONE
  // and clear only when the next start_rx is accepted.
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      is_long     <= 1'b0;
      tcnt        <= '0;
      bit_cnt     <= '0;
      des_reset_q <= 1'b0;
      timeout_q   <= 1'b0;
      dir_q       <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      des_reset_q <= 1'b0;
      unique case (state)
        IDLE: if (bus.start_rx) begin
          is_long     <= bus.long_resp;
          tcnt        <= '0;
          bit_cnt     <= '0;
          timeout_q   <= 1'b0;
          dir_q       <= 1'b0;
          end_q       <= 1'b0;
          des_reset_q <= 1'b1;
        end
        WAIT_START: begin
          if (!bus.cmd_in)          bit_cnt   <= ONE;
          else if (tcnt == TO_LAST) timeout_q <= 1'b1;
          else                      tcnt      <= tcnt + ONE;
        end
        RECEIVE: begin
          if (bit_cnt == ONE && bus.cmd_in)        dir_q <= 1'b1;
          if (bit_cnt == last_idx && !bus.cmd_in)  end_q <= 1'b1;
          // Leaves RECEIVE once bit_cnt reaches LEN, so this saturates there.
          bit_cnt <= bit_cnt + ONE;
        end
        default: ;
      endcase
    end
  end

  assign bus.des_enable  = des_enable_c;
  assign bus.rx_busy     = rx_busy_c;
  assign bus.resp_done   = resp_done_c;
  assign bus.des_reset   = des_reset_q;
  assign bus.timeout_err = timeout_q;
  assign bus.dir_bit_err = dir_q;
  assign bus.end_bit_err = end_q;
  assign bus.bit_index   = bit_cnt;

endmodule

// File: tb/tb_cmd_response_ctrl.sv
// Directed bench for cmd_response_ctrl: short/long frames, timeout and its
// boundary, bit errors, ignored start_rx pulses, and mid-frame reset.
module tb_cmd_response_ctrl;
  logic sd_clock;
  logic reset;
  int   n_assert;
  int   n_fail;
  int   de_count;
  int   done_count;
  int   base_de, base_done;

  cmd_response_ctrl_if #(.CNT_W(8)) bus ();

  cmd_response_ctrl #(
    .TIMEOUT(64), .SHORT_LEN(48), .LONG_LEN(136), .CNT_W(8)
  ) dut (
    .sd_clock (sd_clock),
    .reset    (reset),
    .bus      (bus)
  );

  initial sd_clock = 1'b0;
  always #5 sd_clock = ~sd_clock;

  // Cycle-level event counters, sampled on the inactive edge.
  initial begin
    de_count   = 0;
    done_count = 0;
  end
  always @(negedge sd_clock) begin
    if (bus.des_enable === 1'b1) de_count   = de_count + 1;
    if (bus.resp_done  === 1'b1) done_count = done_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sd_clock);
    #1;
  endtask

  // Drive a frame bit by bit starting with the start bit. pulse_at puts a
  // start_rx pulse on that bit (-1 for none); stop_at truncates the frame.
  task automatic send_frame(input int len, input logic b1, input logic eb,
                            input int pulse_at, input int stop_at);
    for (int i = 0; i < stop_at; i++) begin
      if (i == 0)            bus.cmd_in = 1'b0;
      else if (i == 1)       bus.cmd_in = b1;
      else if (i == len - 1) bus.cmd_in = eb;
      else                   bus.cmd_in = ((i % 3) != 0);
      bus.start_rx = (i == pulse_at);
      tick();
    end
    bus.start_rx = 1'b0;
    bus.cmd_in   = 1'b1;
  endtask

  task automatic start(input logic lng);
    bus.start_rx  = 1'b1;
    bus.long_resp = lng;
    tick();
    bus.start_rx  = 1'b0;
    bus.long_resp = ~lng;   // must be ignored from here on
    base_de   = de_count;
    base_done = done_count;
  endtask

  task automatic idle(input int n);
    bus.cmd_in = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.start_rx  = 1'b0;
    bus.long_resp = 1'b0;
    bus.cmd_in    = 1'b1;
    tick(); tick();
    check("rst_des_enable", 32'(bus.des_enable), 0);
    check("rst_rx_busy",    32'(bus.rx_busy), 0);
    check("rst_resp_done",  32'(bus.resp_done), 0);
    check("rst_des_reset",  32'(bus.des_reset), 0);
    check("rst_errs",       32'({bus.timeout_err, bus.dir_bit_err, bus.end_bit_err}), 0);
    check("rst_bit_index",  32'(bus.bit_index), 0);
    reset = 1'b0;
    tick();

    // 1: short frame after 5 idle cycles
    start(1'b0);
    check("t1_des_reset", 32'(bus.des_reset), 1);
    check("t1_rx_busy",   32'(bus.rx_busy), 1);
    idle(5);
    check("t1_des_reset_low", 32'(bus.des_reset), 0);
    send_frame(48, 1'b0, 1'b1, -1, 48);
    check("t1_resp_done",  32'(bus.resp_done), 1);
    check("t1_errs",       32'({bus.timeout_err, bus.dir_bit_err, bus.end_bit_err}), 0);
    check("t1_bit_index",  32'(bus.bit_index), 48);
    tick();
    check("t1_resp_done_low", 32'(bus.resp_done), 0);
    check("t1_de_count",   32'(de_count - base_de), 48);
    check("t1_done_count", 32'(done_count - base_done), 1);
    check("t1_bit_index_hold", 32'(bus.bit_index), 48);

    // 2: long frame after 10 idle cycles
    start(1'b1);
    check("t2_bit_index_clr", 32'(bus.bit_index), 0);
    idle(10);
    send_frame(136, 1'b0, 1'b1, -1, 136);
    check("t2_resp_done",  32'(bus.resp_done), 1);
    check("t2_errs",       32'({bus.timeout_err, bus.dir_bit_err, bus.end_bit_err}), 0);
    check("t2_bit_index",  32'(bus.bit_index), 136);
    tick();
    check("t2_de_count",   32'(de_count - base_de), 136);
    check("t2_done_count", 32'(done_count - base_done), 1);

    // 3a: timeout, cmd_in high for the full window
    start(1'b0);
    idle(63);
    check("t3_no_done_early", 32'(bus.resp_done), 0);
    check("t3_busy_early",    32'(bus.rx_busy), 1);
    idle(1);
    check("t3_resp_done",   32'(bus.resp_done), 1);
    check("t3_timeout_err", 32'(bus.timeout_err), 1);
    check("t3_rx_busy_done", 32'(bus.rx_busy), 0);
    tick();
    check("t3_de_count",    32'(de_count - base_de), 0);
    check("t3_done_count",  32'(done_count - base_done), 1);
    check("t3_timeout_hold", 32'(bus.timeout_err), 1);

    // 3b: start bit on the last allowed cycle beats the timeout
    start(1'b0);
    check("t3b_timeout_clr", 32'(bus.timeout_err), 0);
    idle(63);
    send_frame(48, 1'b0, 1'b1, -1, 48);
    check("t3b_resp_done",  32'(bus.resp_done), 1);
    check("t3b_timeout",    32'(bus.timeout_err), 0);
    check("t3b_bit_index",  32'(bus.bit_index), 48);
    tick();
    check("t3b_de_count",   32'(de_count - base_de), 48);

    // 4: bad transmission bit and bad end bit
    start(1'b0);
    idle(2);
    send_frame(48, 1'b1, 1'b0, -1, 48);
    check("t4_resp_done",  32'(bus.resp_done), 1);
    check("t4_dir_err",    32'(bus.dir_bit_err), 1);
    check("t4_end_err",    32'(bus.end_bit_err), 1);
    check("t4_timeout",    32'(bus.timeout_err), 0);
    tick();
    check("t4_flags_hold", 32'({bus.dir_bit_err, bus.end_bit_err}), 3);

    // 5: start_rx at frame bit 20 and in the DONE cycle are ignored
    start(1'b0);
    check("t5_flags_clr",  32'({bus.dir_bit_err, bus.end_bit_err}), 0);
    idle(2);
    send_frame(48, 1'b0, 1'b1, 20, 48);
    check("t5_resp_done",  32'(bus.resp_done), 1);
    check("t5_bit_index",  32'(bus.bit_index), 48);
    bus.start_rx = 1'b1;
    tick();
    bus.start_rx = 1'b0;
    check("t5_idle_busy",     32'(bus.rx_busy), 0);
    check("t5_idle_desreset", 32'(bus.des_reset), 0);
    idle(3);
    check("t5_still_idle", 32'(bus.rx_busy), 0);
    check("t5_de_count",   32'(de_count - base_de), 48);
    check("t5_done_count", 32'(done_count - base_done), 1);

    // 6: reset at frame bit 30, then a normal frame
    start(1'b0);
    idle(3);
    send_frame(48, 1'b0, 1'b1, -1, 30);
    check("t6_bit_index_mid", 32'(bus.bit_index), 30);
    check("t6_busy_mid",      32'(bus.rx_busy), 1);
    bus.cmd_in = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_rst_des_enable", 32'(bus.des_enable), 0);
    check("t6_rst_rx_busy",    32'(bus.rx_busy), 0);
    check("t6_rst_bit_index",  32'(bus.bit_index), 0);
    check("t6_rst_resp_done",  32'(bus.resp_done), 0);
    tick();
    reset = 1'b0;
    bus.cmd_in = 1'b1;
    idle(3);
    check("t6_no_done",     32'(done_count - base_done), 0);
    start(1'b0);
    idle(4);
    send_frame(48, 1'b0, 1'b1, -1, 48);
    check("t6_resp_done",   32'(bus.resp_done), 1);
    check("t6_errs",        32'({bus.timeout_err, bus.dir_bit_err, bus.end_bit_err}), 0);
    check("t6_bit_index",   32'(bus.bit_index), 48);
    tick();
    check("t6_de_count",    32'(de_count - base_de), 48);
    check("t6_done_count",  32'(done_count - base_done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cmd_response_ctrl.md
Name: cmd_response_ctrl

Overview:
- Sequencing controller for the CMD-line serial-to-parallel deserializer in the SD host.
- After the host issues a command, it waits for the card's response start bit and keeps the deserializer enabled for exactly one response frame.
- Frame length is 48 bits (short response) or 136 bits (R2 response).
- Checks the transmission bit and end bit, flags a response timeout, and reports completion to the CMD top-level FSM.

Parameters:
- TIMEOUT, 64, maximum sd_clock cycles (NCR) to wait for the start bit after start_rx.
- SHORT_LEN, 48, bits in a short response frame, start and end bits included.
- LONG_LEN, 136, bits in a long (R2) response frame, start and end bits included.
- CNT_W, 8, width of the bit and timeout counters; must hold max(LONG_LEN, TIMEOUT).

Ports:
- sd_clock  input  1  single clock; all state updates on its posedge.
- reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs.
- start_rx  input  1  one-cycle pulse from the CMD FSM: command sent, begin listening.
- long_resp  input  1  sampled with start_rx; 1 selects LONG_LEN, 0 selects SHORT_LEN.
- cmd_in  input  1  CMD line, already synchronised to sd_clock.
- des_enable  output  1  enable to the deserializer; high on every cycle whose cmd_in bit belongs to the frame.
- des_reset  output  1  one-cycle clear pulse to the deserializer.
- rx_busy  output  1  high in WAIT_START and RECEIVE.
- resp_done  output  1  one-cycle pulse: frame finished or timed out.
- timeout_err  output  1  no start bit within TIMEOUT cycles.
- dir_bit_err  output  1  transmission bit (frame bit 1) was 1.
- end_bit_err  output  1  last frame bit was 0.
- bit_index  output  CNT_W  number of frame bits captured so far.

Behaviour:
- Reset values: state=IDLE; bit_index=0; all other outputs 0; internal counters 0.
- States:
  - IDLE: on start_rx, latch frame length from long_resp, clear all three error flags, pulse des_reset for that cycle (registered, so it is high during the next cycle), go to WAIT_START.
  - WAIT_START: rx_busy=1. des_enable is combinational and equals (cmd_in==0), so the start bit is captured on the same edge it is detected.
    - On cmd_in==0: bit_index<=1, go to RECEIVE.
    - Otherwise the timeout counter increments.
    - When the counter reaches TIMEOUT-1 with cmd_in==1: timeout_err<=1, go to DONE.
    - A start bit on the final allowed cycle takes priority over the timeout.
  - RECEIVE: des_enable=1, rx_busy=1. bit_index increments on each posedge.
    - At bit_index==1: if cmd_in==1, set dir_bit_err.
    - At bit_index==LEN-1: if cmd_in==0, set end_bit_err; bit_index<=LEN; go to DONE.
  - DONE: resp_done=1 for exactly one cycle, then go to IDLE. des_enable=0, rx_busy=0.
- Total des_enable-high cycles per frame is exactly LEN: 48 or 136.
- Latency: resp_done rises 1 cycle after the end-bit edge. On timeout it rises TIMEOUT+1 cycles after start_rx.
- Error flags and bit_index persist after DONE until the next accepted start_rx or reset.
- start_rx outside IDLE is ignored; the current frame continues unaffected.
- start_rx arriving in the DONE cycle is also ignored.
- long_resp changes outside the start_rx cycle have no effect.
- Reset asserted mid-frame: immediate return to IDLE, des_enable=0, no resp_done pulse.
- Counters never wrap: the bit counter saturates at LEN, the timeout counter at TIMEOUT-1.

Test Plan:
1. start_rx with long_resp=0; cmd_in idles high 5 cycles, then sends a 48-bit frame (bit1=0, end=1) -> des_enable high exactly 48 cycles starting on the start-bit cycle; resp_done one cycle later; all err=0; bit_index=48.
2. start_rx with long_resp=1; 136-bit frame, start bit after 10 cycles -> des_enable high 136 cycles; resp_done pulse; all err=0; bit_index=136.
3. start_rx; cmd_in held high 64 cycles -> timeout_err=1 with resp_done 65 cycles after start_rx; des_enable never high. Repeat with the start bit on cycle 63 -> no timeout, normal frame.
4. 48-bit frame with bit1=1 and last bit=0 -> dir_bit_err=1, end_bit_err=1 at resp_done; both flags cleared on the next start_rx.
5. Second start_rx pulse at frame bit 20, and another in the DONE cycle -> both ignored; single resp_done; des_enable count still 48.
6. Reset asserted at frame bit 30, then a new start_rx -> immediate IDLE with outputs 0 and no resp_done; next frame completes normally.
